// File: rtl/assoc_wb_cache_if.sv
// CPU-side and memory-side bus bundle for assoc_wb_cache.
// slave = the cache, master = the CPU/memory environment.
interface assoc_wb_cache_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter int MADDR_W = 28,
  parameter int MDATA_W = 128
);
  logic                   cpu_req_valid;
  logic                   cpu_req_ready;
  logic [ADDR_W-1:0]      cpu_req_addr;
  logic [DATA_W-1:0]      cpu_req_data;
  logic [DATA_W/8-1:0]    cpu_req_write;
  logic                   cpu_resp_valid;
  logic [DATA_W-1:0]      cpu_resp_data;
  logic                   mem_req_valid;
  logic                   mem_req_ready;
  logic [MADDR_W-1:0]     mem_req_addr;
  logic                   mem_req_rw;
  logic                   mem_req_data_valid;
  logic                   mem_req_data_ready;
  logic [MDATA_W-1:0]     mem_req_data_bits;
  logic [MDATA_W/8-1:0]   mem_req_data_mask;
  logic                   mem_resp_valid;
  logic [MDATA_W-1:0]     mem_resp_data;

  modport slave (
    input  cpu_req_valid, cpu_req_addr,
    input  cpu_req_data, cpu_req_write,
    output cpu_req_ready,
    output cpu_resp_valid, cpu_resp_data,
    output mem_req_valid, mem_req_addr, mem_req_rw,
    input  mem_req_ready,
    output mem_req_data_valid,
    output mem_req_data_bits, mem_req_data_mask,
    input  mem_req_data_ready,
    input  mem_resp_valid, mem_resp_data
  );

  modport master (
    output cpu_req_valid, cpu_req_addr,
    output cpu_req_data, cpu_req_write,
    input  cpu_req_ready,
    input  cpu_resp_valid, cpu_resp_data,
    input  mem_req_valid, mem_req_addr, mem_req_rw,
    output mem_req_ready,
    input  mem_req_data_valid,
    input  mem_req_data_bits, mem_req_data_mask,
    output mem_req_data_ready,
    output mem_resp_valid, mem_resp_data
  );
endinterface

// File: rtl/assoc_wb_cache.sv
// N-way set-associative write-back write-allocate cache,
// round-robin replacement, burst refill and dirty eviction.
module assoc_wb_cache #(
  parameter int SETS = 64,
  parameter int WAYS = 2,
  parameter int CPU_WIDTH = 32,
  parameter int WORD_ADDR_BITS = 30,
  parameter int BEATS = 4
) (
  input logic clk,
  input logic reset,
  assoc_wb_cache_if.slave bus
);
  localparam int MEM_W = 128;
  localparam int WPB = MEM_W / CPU_WIDTH;
  localparam int WB_BITS = $clog2(WPB);
  localparam int BT_BITS = $clog2(BEATS);
  localparam int OFF = WB_BITS + BT_BITS;
  localparam int IDX_BITS = $clog2(SETS);
  localparam int TAG_BITS = WORD_ADDR_BITS - OFF - IDX_BITS;
  localparam int WAY_BITS = WAYS > 1 ? $clog2(WAYS) : 1;
  localparam int LA_BITS = WORD_ADDR_BITS - WB_BITS;
  localparam int NB = CPU_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, WB_REQ, WB_DATA, FILL_REQ, FILL_DATA
  } state_t;

  state_t state, nxt;

  logic [WORD_ADDR_BITS-1:0] req_addr;
  logic [CPU_WIDTH-1:0]      req_data;
  logic [NB-1:0]             req_we;
  logic [WAY_BITS-1:0]       victim_q;
  logic [BT_BITS-1:0]        cnt;

  logic [SETS-1:0][WAYS-1:0]     valid_q;
  logic [SETS-1:0][WAYS-1:0]     dirty_q;
  logic [SETS-1:0][WAY_BITS-1:0] rr_q;

  logic [MEM_W-1:0]    data_mem [WAYS][SETS*BEATS];
  logic [TAG_BITS-1:0] tag_mem  [WAYS][SETS];
  logic [MEM_W-1:0]    rd_data  [WAYS];
  logic [TAG_BITS-1:0] rd_tag   [WAYS];

  logic [IDX_BITS-1:0] req_idx, rd_idx;
  logic [TAG_BITS-1:0] req_tag;
  logic [BT_BITS-1:0]  req_beat, rd_beat;
  logic [WB_BITS-1:0]  req_word;

  assign req_idx  = req_addr[OFF +: IDX_BITS];
  assign req_tag  = req_addr[WORD_ADDR_BITS-1 -: TAG_BITS];
  assign req_beat = req_addr[WB_BITS +: BT_BITS];
  assign req_word = req_addr[0 +: WB_BITS];

  logic wb_fire, fill_fire, last;
  assign wb_fire = (state == WB_DATA) && bus.mem_req_data_ready;
  assign fill_fire = (state == FILL_DATA) && bus.mem_resp_valid;
  assign last = (cnt == BT_BITS'(BEATS - 1));

  logic [WAYS-1:0]     hit_vec;
  logic [WAY_BITS-1:0] hit_way, vic;
  logic                hit, vic_dirty;
  logic [MEM_W-1:0]    merged;

  always_comb begin
    hit_way = '0;
    vic = rr_q[req_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      hit_vec[w] = valid_q[req_idx][w] &&
                   (rd_tag[w] == req_tag);
      if (hit_vec[w]) hit_way = WAY_BITS'(w);
      if (!valid_q[req_idx][w]) vic = WAY_BITS'(w);
    end
    hit = (hit_vec != '0) &&
          ((hit_vec & (hit_vec - 1'b1)) == '0);
    vic_dirty = valid_q[req_idx][vic] &
                dirty_q[req_idx][vic];
  end

  // Byte-merge the store into the beat read at accept time.
  always_comb begin
    merged = rd_data[hit_way];
    for (int b = 0; b < NB; b++)
      if (req_we[b])
        merged[int'(req_word) * CPU_WIDTH + b * 8 +: 8] =
          req_data[b * 8 +: 8];
  end

  always_comb begin
    rd_idx = req_idx;
    rd_beat = req_beat;
    unique case (state)
      IDLE: begin
        rd_idx = bus.cpu_req_addr[OFF +: IDX_BITS];
        rd_beat = bus.cpu_req_addr[WB_BITS +: BT_BITS];
      end
      WB_REQ: rd_beat = '0;
      WB_DATA: rd_beat = wb_fire ? cnt + 1'b1 : cnt;
      default: ;
    endcase
  end

  logic                 req_ready, resp_valid, store_we;
  logic                 m_valid, m_rw, d_valid;
  logic [LA_BITS-1:0]   m_addr;
  logic [MEM_W-1:0]     d_bits;
  logic [MEM_W/8-1:0]   d_mask;

  always_comb begin
    nxt = state;
    req_ready = 1'b0;
    resp_valid = 1'b0;
    store_we = 1'b0;
    m_valid = 1'b0;
    m_rw = 1'b0;
    m_addr = '0;
    d_valid = 1'b0;
    d_bits = '0;
    d_mask = '0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.cpu_req_valid) nxt = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          resp_valid = (req_we == '0);
          store_we = (req_we != '0);
          nxt = IDLE;
        end else begin
          nxt = vic_dirty ? WB_REQ : FILL_REQ;
        end
      end
      WB_REQ: begin
        m_valid = 1'b1;
        m_rw = 1'b1;
        m_addr = {rd_tag[victim_q], req_idx, BT_BITS'(0)};
        if (bus.mem_req_ready) nxt = WB_DATA;
      end
      WB_DATA: begin
        d_valid = 1'b1;
        d_bits = rd_data[victim_q];
        d_mask = '1;
        if (wb_fire && last) nxt = FILL_REQ;
      end
      FILL_REQ: begin
        m_valid = 1'b1;
        m_addr = {req_tag, req_idx, BT_BITS'(0)};
        if (bus.mem_req_ready) nxt = FILL_DATA;
      end
      FILL_DATA: begin
        if (fill_fire && last) nxt = LOOKUP;
      end
      default: nxt = IDLE;
    endcase
  end

  assign bus.cpu_req_ready = req_ready;
  assign bus.cpu_resp_valid = resp_valid;
  assign bus.cpu_resp_data = resp_valid ?
    rd_data[hit_way][int'(req_word) * CPU_WIDTH +: CPU_WIDTH] : '0;
  assign bus.mem_req_valid = m_valid;
  assign bus.mem_req_rw = m_rw;
  assign bus.mem_req_addr = m_addr;
  assign bus.mem_req_data_valid = d_valid;
  assign bus.mem_req_data_bits = d_bits;
  assign bus.mem_req_data_mask = d_mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
      rr_q <= '0;
      cnt <= '0;
      victim_q <= '0;
      req_addr <= '0;
      req_data <= '0;
      req_we <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && bus.cpu_req_valid) begin
        req_addr <= bus.cpu_req_addr;
        req_data <= bus.cpu_req_data;
        req_we <= bus.cpu_req_write;
      end
      if (state == LOOKUP && !hit) begin
        victim_q <= vic;
        cnt <= '0;
      end
      if (store_we) dirty_q[req_idx][hit_way] <= 1'b1;
      if (wb_fire) cnt <= cnt + 1'b1;
      if (fill_fire) begin
        cnt <= cnt + 1'b1;
        if (last) begin
          valid_q[req_idx][victim_q] <= 1'b1;
          dirty_q[req_idx][victim_q] <= 1'b0;
          rr_q[req_idx] <=
            (victim_q == WAY_BITS'(WAYS - 1)) ?
            '0 : victim_q + 1'b1;
        end
      end
    end
  end

  // Read every cycle; forward a same-cycle refill write so the replay sees it.
  always_ff @(posedge clk) begin
    for (int w = 0; w < WAYS; w++) begin
      rd_data[w] <= data_mem[w][{rd_idx, rd_beat}];
      rd_tag[w] <= tag_mem[w][rd_idx];
      if (fill_fire && WAY_BITS'(w) == victim_q) begin
        if (rd_beat == cnt)
          rd_data[w] <= bus.mem_resp_data;
        if (last) rd_tag[w] <= req_tag;
      end
    end
    if (fill_fire) begin
      data_mem[victim_q][{req_idx, cnt}] <= bus.mem_resp_data;
      if (last) tag_mem[victim_q][req_idx] <= req_tag;
    end
    if (store_we)
      data_mem[hit_way][{req_idx, req_beat}] <= merged;
  end
endmodule
